// File: rtl/cache_pkg.sv
// Shared state, metadata type and geometry helpers for the direct-mapped write-back cache.
package cache_pkg;

  // Widest tag the metadata store can hold; narrower tags are zero-extended.
  localparam int unsigned MAX_TAG_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWbCmd,
    StWbData,
    StRfCmd,
    StRfData,
    StResp
  } cache_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } line_meta_t;

  function automatic int unsigned get_offset_w(int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned get_index_w(int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned get_tag_w(int unsigned addr_w, int unsigned line_words,
                                            int unsigned lines);
    return addr_w - $clog2(line_words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_dm_wb_param_if.sv
// CPU request/response and burst memory signals of the cache; slave = cache side.
interface cache_dm_wb_param_if #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 16
);
  localparam int unsigned BLK_W = ADDR_W - $clog2(LINE_WORDS);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_write;
  logic [BLK_W-1:0]  mem_cmd_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_cmd_ready, mem_wready,
           mem_rdata, mem_rvalid,
    output req_ready, resp_valid, resp_rdata, mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
           mem_wdata, mem_wvalid
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_cmd_ready, mem_wready,
           mem_rdata, mem_rvalid,
    input  req_ready, resp_valid, resp_rdata, mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
           mem_wdata, mem_wvalid
  );
endinterface

// File: rtl/cache_meta_array.sv
// Per-line valid/dirty/tag store: async clear, one read port, one write port, dirty strobes.
module cache_meta_array
  import cache_pkg::*;
#(
  parameter int unsigned LINES   = 1024,
  parameter int unsigned INDEX_W = $clog2(LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output line_meta_t         rd_meta,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  line_meta_t         wr_meta,
  input  logic               set_dirty,
  input  logic               clr_dirty
);

  line_meta_t meta_q [LINES];

  assign rd_meta = meta_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LINES); i++) meta_q[i] <= '0;
    end else begin
      if (wr_en)     meta_q[wr_idx]       <= wr_meta;
      if (set_dirty) meta_q[wr_idx].dirty <= 1'b1;
      if (clr_dirty) meta_q[wr_idx].dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/cache_dm_wb_param.sv
// Direct-mapped write-back write-allocate cache; optional counters under CACHE_STATS_EN.
module cache_dm_wb_param
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned LINES      = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_dm_wb_param_if.slave   bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [31:0]          stat_writebacks
`endif
);

  localparam int unsigned OFFSET_W = get_offset_w(LINE_WORDS);
  localparam int unsigned INDEX_W  = get_index_w(LINES);
  localparam int unsigned TAG_W    = get_tag_w(ADDR_W, LINE_WORDS, LINES);

  cache_state_t state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic                hit, last_beat;
  line_meta_t          meta_rd, meta_wdata;
  logic                meta_we, set_dirty, clr_dirty;

  logic [DATA_W-1:0]           data_q [LINES*LINE_WORDS];
  logic                        data_we;
  logic [INDEX_W+OFFSET_W-1:0] data_waddr;
  logic [DATA_W-1:0]           data_wdata;

  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign idx       = addr_q[OFFSET_W +: INDEX_W];
  assign off       = addr_q[OFFSET_W-1:0];
  assign hit       = meta_rd.valid && (meta_rd.tag == MAX_TAG_W'(tag));
  assign last_beat = (cnt_q == OFFSET_W'(LINE_WORDS - 1));

  cache_meta_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W)
  ) u_meta (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx),
    .rd_meta   (meta_rd),
    .wr_en     (meta_we),
    .wr_idx    (idx),
    .wr_meta   (meta_wdata),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    meta_we      = 1'b0;
    meta_wdata   = '{valid: 1'b1, dirty: 1'b0, tag: MAX_TAG_W'(tag)};
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    data_we      = 1'b0;
    data_waddr   = {idx, off};
    data_wdata   = wdata_q;
    bus.req_ready     = 1'b0;
    bus.mem_cmd_valid = 1'b0;
    bus.mem_cmd_write = 1'b0;
    bus.mem_cmd_addr  = '0;
    bus.mem_wvalid    = 1'b0;
    bus.mem_wdata     = '0;
    case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          data_we   = write_q;
          set_dirty = write_q;
          state_d   = StResp;
        end else if (meta_rd.valid && meta_rd.dirty) begin
          state_d = StWbCmd;
        end else begin
          state_d = StRfCmd;
        end
      end
      StWbCmd: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_write = 1'b1;
        bus.mem_cmd_addr  = {meta_rd.tag[TAG_W-1:0], idx};
        if (bus.mem_cmd_ready) state_d = StWbData;
      end
      StWbData: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = data_q[{idx, cnt_q}];
        if (bus.mem_wready) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (last_beat) begin
            clr_dirty = 1'b1;
            state_d   = StRfCmd;
          end
        end
      end
      StRfCmd: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_addr  = {tag, idx};
        if (bus.mem_cmd_ready) state_d = StRfData;
      end
      StRfData: begin
        if (bus.mem_rvalid) begin
          data_we    = 1'b1;
          data_waddr = {idx, cnt_q};
          data_wdata = bus.mem_rdata;
          cnt_d      = cnt_q + OFFSET_W'(1);
          if (last_beat) begin
            // Line becomes valid and clean; the repeated lookup then hits and merges writes.
            meta_we = 1'b1;
            state_d = StLookup;
          end
        end
      end
      StResp: begin
        resp_valid_d = 1'b1;
        if (!write_q) resp_rdata_d = data_q[{idx, off}];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[data_waddr] <= data_wdata;
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    if (state_q == StLookup && hit && hits_q != '1)        hits_d   = hits_q + 32'd1;
    if (state_q == StLookup && !hit && misses_q != '1)     misses_d = misses_q + 32'd1;
    if (state_q == StWbData && bus.mem_wready && last_beat && wbs_q != '1)
      wbs_d = wbs_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif

endmodule
